led_blink_ctrl: RTL and testbench
=================================

Name: led_blink_ctrl

Overview:
- Programmable LED sequencer built around a free-running half-period tick counter.
- Replaces fixed-rate divider-driven blinking with run-time selectable modes: OFF, SOLID, BLINK and one-shot BURST.
- Sits between the board clock and the LED pin. Configured by a simple valid/ready port from a host, button logic or top-level FSM.
- Comes out of reset blinking at 1 Hz with a 50 MHz clock.

Parameters:
- CLK_HZ, 50000000, board clock frequency; informational, used only to derive DEF_HALF.
- DIV_W, 26, width of the half-period counter and of cfg_half.
- DEF_HALF, 25000000, half-period in clk_in cycles loaded at reset; gives 1 Hz blinking.
- BURST_W, 4, width of the burst pulse counter and of cfg_count.

Ports:
- clk_in  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready on a rising edge of clk_in.
- cfg_mode  in  2  requested mode: 0 OFF, 1 SOLID, 2 BLINK, 3 BURST.
- cfg_half  in  DIV_W  half-period in clk_in cycles; 0 is treated as 1.
- cfg_count  in  BURST_W  number of on-pulses in BURST mode; 0 is treated as 1.
- led  out  1  LED drive, registered.
- tick  out  1  single-cycle pulse at every half-period boundary, registered.
- busy  out  1  high while a BURST is in progress.

Behaviour:
- Reset (async, active-high, one clock clk_in):
  - led=0, tick=0, busy=0, cfg_ready=1.
  - Mode register = BLINK, half register = DEF_HALF, counter = 0, pulse count = 0.
  - Asserting rst mid-burst aborts the burst immediately.
- Half-period counter:
  - Increments every cycle.
  - On the edge where counter == half-1: counter <= 0 and tick <= 1. Otherwise tick <= 0.
  - Tick period = half cycles. The first tick after reset or after a config accept occurs on the half-th edge.
  - half=1 gives tick high every cycle.
- cfg_ready = !busy, combinational from the busy register.
- Config accept:
  - On an edge with cfg_valid && cfg_ready, latch mode, half (max(cfg_half,1)) and count (max(cfg_count,1)).
  - Also on that edge: counter <= 0, tick <= 0, pulse count <= 0.
  - Accept takes priority over a tick on the same edge; that tick is suppressed.
- FSM states:
  - S_OFF: led=0. Ticks still generated. Stays until the next accept.
  - S_SOLID: led=1. Ticks still generated.
  - S_BLINK: led=1 on the accept edge, or led=0 when entered from reset. led toggles on every tick edge.
  - S_BURST_ON: led=1, busy=1. On tick -> S_BURST_OFF with led=0.
  - S_BURST_OFF: led=0, busy=1. On tick, increment pulse count. If the new count == count -> S_OFF with busy=0, else -> S_BURST_ON with led=1.
- Accept edge updates led and busy directly: OFF->0, SOLID->1, BLINK->1, BURST->led=1 and busy=1.
- BURST timing: total busy duration = 2*count*half cycles from the accept edge. busy falls on the same edge as the final tick.
- cfg_valid held high while busy: no accept. It is accepted on the first edge after busy falls, i.e. the edge following the final tick.
- No other outputs are combinational.

Decomposition:
- Shared package led_pkg holds:
  - mode encoding constants MODE_OFF=0, MODE_SOLID=1, MODE_BLINK=2, MODE_BURST=3
  - FSM state encoding
  - DEF_HALF_1HZ = 25000000
- One natural sub-module: half_tick_gen.
  - Holds the counter and the tick register.
  - Inputs: clk_in, rst, half, restart.
  - Output: tick.
  - Sequencing FSM stays in led_blink_ctrl.

Test Plan (DEF_HALF overridden to 5):
- Release rst, idle -> tick pulses on cycles 5, 10, 15; led 0 ->1 at cycle 5, ->0 at cycle 10, ->1 at cycle 15.
- Accept mode=SOLID with half=3 -> led=1 on the accept edge and stays 1; tick every 3 cycles; busy=0 throughout.
- Accept mode=BURST, half=2, count=3 -> led pattern 1,1,0,0 repeated 3 times (12 cycles); busy high 12 cycles, then low; final state OFF with led=0.
- During that burst hold cfg_valid=1 with mode=BLINK -> cfg_ready=0 for all 12 cycles; accepted on cycle 13; led=1 then toggles every half cycles.
- cfg_half=0 with cfg_count=0 in BURST -> treated as half=1, count=1: led=1 for 1 cycle, 0 for 1 cycle, busy high 2 cycles.
- Assert rst asynchronously mid-burst (between edges) -> led, busy and tick go 0 immediately; cfg_ready=1; after release, BLINK resumes with a tick at cycle 5.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: host mode codes, FSM states and default timing.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  // Half-period at 50 MHz for 1 Hz blinking.
  localparam int unsigned DEF_HALF_1HZ = 25000000;

  typedef enum logic [2:0] {
    StOff,
    StSolid,
    StBlink,
    StBurstOn,
    StBurstOff
  } led_state_e;

endpackage

// File: rtl/half_tick_gen.sv
// Free-running half-period counter with a registered single-cycle tick.
// wrap is the terminal-count strobe, so the sequencer can update on the same edge as tick.
module half_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV_W = 26
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] half,
  input  logic             restart,
  output logic             wrap,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    wrap   = (cnt_q == (half - DIV_W'(1)));
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Programmable LED sequencer: OFF, SOLID, BLINK and one-shot BURST modes,
// configured over a valid/ready port and paced by half_tick_gen.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DIV_W    = 26,
  parameter int unsigned DEF_HALF = CLK_HZ / 2,
  parameter int unsigned BURST_W  = 4
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [DIV_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_count,
  output logic               led,
  output logic               tick,
  output logic               busy
);

  led_state_e         state_q;
  logic [DIV_W-1:0]   half_q;
  logic [BURST_W-1:0] count_q;
  logic [BURST_W-1:0] pulse_q;
  logic               led_q;
  logic               busy_q;

  logic               accept;
  logic               wrap;
  logic [DIV_W-1:0]   half_sat;
  logic [BURST_W-1:0] count_sat;
  logic [BURST_W-1:0] pulse_inc;

  always_comb begin
    accept    = cfg_valid && !busy_q;
    half_sat  = (cfg_half == '0) ? DIV_W'(1) : cfg_half;
    count_sat = (cfg_count == '0) ? BURST_W'(1) : cfg_count;
    pulse_inc = pulse_q + BURST_W'(1);
  end

  // Restart on accept clears the counter and suppresses a coincident tick.
  half_tick_gen #(
    .DIV_W (DIV_W)
  ) u_half_tick_gen (
    .clk_in  (clk_in),
    .rst     (rst),
    .half    (half_q),
    .restart (accept),
    .wrap    (wrap),
    .tick    (tick)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StBlink;
      half_q  <= DIV_W'(DEF_HALF);
      count_q <= BURST_W'(1);
      pulse_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      half_q  <= half_sat;
      count_q <= count_sat;
      pulse_q <= '0;
      unique case (cfg_mode)
        MODE_OFF: begin
          state_q <= StOff;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        MODE_SOLID: begin
          state_q <= StSolid;
          led_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        MODE_BLINK: begin
          state_q <= StBlink;
          led_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        MODE_BURST: begin
          state_q <= StBurstOn;
          led_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end else if (wrap) begin
      unique case (state_q)
        StOff, StSolid: ;
        StBlink: led_q <= !led_q;
        StBurstOn: begin
          state_q <= StBurstOff;
          led_q   <= 1'b0;
        end
        StBurstOff: begin
          pulse_q <= pulse_inc;
          if (pulse_inc == count_q) begin
            state_q <= StOff;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StBurstOn;
            led_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StOff;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = !busy_q;
  assign led       = led_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: a time-since-event reference model pushes expected
// outputs per edge; an independent monitor pops and compares after each rising edge.
module tb_led_blink_ctrl;

  localparam int unsigned DIV_W    = 26;
  localparam int unsigned BURST_W  = 4;
  localparam int unsigned DEF_HALF = 5;

  logic               clk_in = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_mode = 2'd0;
  logic [DIV_W-1:0]   cfg_half = '0;
  logic [BURST_W-1:0] cfg_count = '0;
  logic               led;
  logic               tick;
  logic               busy;

  led_blink_ctrl #(
    .CLK_HZ   (50000000),
    .DIV_W    (DIV_W),
    .DEF_HALF (DEF_HALF),
    .BURST_W  (BURST_W)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_count (cfg_count),
    .led       (led),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic led;
    logic tick;
    logic busy;
    logic ready;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: outputs are a pure function of mode, half, count and edges since last event.
  int m_mode, m_half, m_count, m_t, m_start;

  function automatic exp_t expect_now();
    exp_t e;
    int   n;
    n      = m_t / m_half;
    e.tick = (m_t > 0) && (m_t % m_half == 0);
    e.led  = 1'b0;
    e.busy = 1'b0;
    case (m_mode)
      0: ;
      1: e.led = 1'b1;
      2: e.led = m_start[0] ^ n[0];
      default: begin
        if (m_t < 2 * m_count * m_half) begin
          e.busy = 1'b1;
          e.led  = !n[0];
        end
      end
    endcase
    e.ready = !e.busy;
    return e;
  endfunction

  task automatic model_reset();
    m_mode  = 2;
    m_half  = DEF_HALF;
    m_count = 1;
    m_t     = 0;
    m_start = 0;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0b required=%0b", name, $time, act, req);
    end
  endtask

  // Called at a falling edge: drive, predict the next rising edge, then advance.
  task automatic cycle(input bit v, input int mode, input int half, input int count);
    exp_t cur;
    cur       = expect_now();
    cfg_valid = v;
    cfg_mode  = 2'(mode);
    cfg_half  = DIV_W'(half);
    cfg_count = BURST_W'(count);
    if (v && cur.ready) begin
      m_mode  = mode;
      m_half  = (half == 0) ? 1 : half;
      m_count = (count == 0) ? 1 : count;
      m_t     = 0;
      m_start = 1;
    end else begin
      m_t++;
    end
    sb.push_back(expect_now());
    @(negedge clk_in);
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check1("led", led, e.led);
        check1("tick", tick, e.tick);
        check1("busy", busy, e.busy);
        check1("cfg_ready", cfg_ready, e.ready);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check1("reset_led", led, 1'b0);
    check1("reset_tick", tick, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    model_reset();

    repeat (16) cycle(1'b0, 0, 0, 0);
    cycle(1'b1, 1, 3, 0);
    repeat (9) cycle(1'b0, 0, 0, 0);
    // Burst with a BLINK request held pending until busy falls.
    cycle(1'b1, 3, 2, 3);
    repeat (13) cycle(1'b1, 2, 4, 0);
    repeat (12) cycle(1'b0, 0, 0, 0);
    cycle(1'b1, 3, 0, 0);
    repeat (4) cycle(1'b0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
    end
    repeat (45) cycle(1'b0, 0, 0, 0);

    // Mid-burst asynchronous reset, asserted between edges while led is high.
    cycle(1'b1, 3, 3, 2);
    repeat (7) cycle(1'b0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check1("async_led", led, 1'b0);
    check1("async_busy", busy, 1'b0);
    check1("async_tick", tick, 1'b0);
    check1("async_ready", cfg_ready, 1'b1);
    @(negedge clk_in);
    rst = 1'b0;
    model_reset();
    repeat (12) cycle(1'b0, 0, 0, 0);

    repeat (2) @(posedge clk_in);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
